// File: rtl/uart_reg_bridge.sv
// Register peek/poke responder: decodes write (0x57 ADDR DATA) and read (0x52 ADDR)
// frames from the UART RX FIFO, drives an 8-bit register bus, and queues the reply byte.
module uart_reg_bridge #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_empty,
  output logic              rx_rden,
  output logic [7:0]        tx_byte,
  input  logic              tx_full,
  output logic              tx_wren,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_WAIT,
    S_SEND
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic rx_ok;
  logic expired;
  logic pop, we, re, wren, ferr;

  // Pops are qualified by rst_n so no byte is taken while reset is held.
  assign rx_ok   = rst_n && !rx_empty;
  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    cnt_d     = '0;
    tx_byte_d = tx_byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pop       = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    wren      = 1'b0;
    ferr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_ok) begin
          pop = 1'b1;
          if (rx_byte == CMD_WR) begin
            wr_d    = 1'b1;
            state_d = S_GET_ADDR;
          end else if (rx_byte == CMD_RD) begin
            wr_d    = 1'b0;
            state_d = S_GET_ADDR;
          end else begin
            tx_byte_d = NAK;
            ferr      = 1'b1;
            state_d   = S_SEND;
          end
        end
      end

      S_GET_ADDR: begin
        if (rx_ok) begin
          pop     = 1'b1;
          addr_d  = rx_byte[ADDR_W-1:0];
          state_d = wr_q ? S_GET_DATA : S_BUS_RD;
        end else if (expired) begin
          ferr    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GET_DATA: begin
        if (rx_ok) begin
          pop     = 1'b1;
          wdata_d = rx_byte;
          state_d = S_BUS_WR;
        end else if (expired) begin
          ferr    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BUS_WR: begin
        we        = 1'b1;
        tx_byte_d = ACK;
        state_d   = S_SEND;
      end

      S_BUS_RD: begin
        re      = 1'b1;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        tx_byte_d = reg_rdata;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (!tx_full) begin
          wren    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rx_rden   = pop;
  assign tx_wren   = wren;
  assign reg_we    = we;
  assign reg_re    = re;
  assign frame_err = ferr;
  assign tx_byte   = tx_byte_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: FIFO/register-slave models, a frame-level reference
// model that predicts bus accesses and reply bytes, and directed scenarios.
module tb_uart_reg_bridge;

  localparam int TO = 16;

  logic       CLK;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_empty;
  logic       rx_rden;
  logic [7:0] tx_byte;
  logic       tx_full;
  logic       tx_wren;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;

  uart_reg_bridge #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_empty  (rx_empty),
    .rx_rden   (rx_rden),
    .tx_byte   (tx_byte),
    .tx_full   (tx_full),
    .tx_wren   (tx_wren),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  logic [7:0] rxq[$];
  logic [7:0] mdl_buf[$];
  logic [7:0] bus_regs [256];
  logic [7:0] mdl_regs [256];
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int         exp_ferr;

  int checks, errors;
  int cyc;
  int n_pop, n_we, n_re, n_wren, n_ferr;
  int pop_cyc, we_cyc, re_cyc, wren_cyc, ferr_cyc;
  logic [7:0] last_tx;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: consumes complete frames from the model buffer.
  task automatic model_parse();
    bus_t e;
    while (mdl_buf.size() > 0) begin
      if (mdl_buf[0] == 8'h57) begin
        if (mdl_buf.size() < 3) break;
        e = {1'b1, mdl_buf[1], mdl_buf[2]};
        mdl_regs[mdl_buf[1]] = mdl_buf[2];
        exp_bus.push_back(e);
        exp_tx.push_back(8'h06);
        repeat (3) void'(mdl_buf.pop_front());
      end else if (mdl_buf[0] == 8'h52) begin
        if (mdl_buf.size() < 2) break;
        e = {1'b0, mdl_buf[1], 8'h00};
        exp_bus.push_back(e);
        exp_tx.push_back(mdl_regs[mdl_buf[1]]);
        repeat (2) void'(mdl_buf.pop_front());
      end else begin
        exp_tx.push_back(8'h15);
        exp_ferr++;
        void'(mdl_buf.pop_front());
      end
    end
  endtask

  task automatic rx_update();
    rx_empty = (rxq.size() == 0);
    rx_byte  = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic feed(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input bit modeled);
    logic [7:0] b [3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int i = 0; i < n; i++) begin
      rxq.push_back(b[i]);
      if (modeled) mdl_buf.push_back(b[i]);
    end
    if (modeled) model_parse();
    rx_update();
  endtask

  // One clock: sample DUT requests mid-cycle, apply FIFO pop / register slave after the edge.
  task automatic tick();
    logic       pop, we, re;
    logic [7:0] a, d;
    @(negedge CLK);
    pop = rx_rden; we = reg_we; re = reg_re; a = reg_addr; d = reg_wdata;
    @(posedge CLK);
    #1;
    if (pop && rxq.size() > 0) void'(rxq.pop_front());
    if (we) bus_regs[a] = d;
    reg_rdata = re ? bus_regs[a] : (bus_regs[a] ^ 8'hFF);
    rx_update();
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return n_pop;
      1:       return n_re;
      default: return n_wren;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int budget);
    int i;
    i = 0;
    while (i < budget && cnt_of(which) < target) begin
      tick();
      i++;
    end
    chk({name, "_reached"}, int'(cnt_of(which) >= target), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int  i;
    bit  done;
    i = 0;
    done = 1'b0;
    while (i < budget && !done) begin
      done = !busy && rxq.size() == 0 && exp_tx.size() == 0 && exp_bus.size() == 0 && exp_ferr == 0;
      if (!done) begin
        tick();
        i++;
      end
    end
    chk({name, "_done"}, int'(done), 1);
  endtask

  always @(negedge CLK) begin : compare
    bus_t e;
    cyc++;
    chk("we_re_exclusive", int'(reg_we && reg_re), 0);
    chk("rden_wren_exclusive", int'(rx_rden && tx_wren), 0);
    chk("rden_while_empty", int'(rx_rden && rx_empty), 0);
    chk("wren_while_full", int'(tx_wren && tx_full), 0);
    if (rx_rden) begin
      n_pop++;
      pop_cyc = cyc;
    end
    if (reg_we || reg_re) begin
      if (exp_bus.size() == 0) begin
        chk("unexpected_bus_strobe", 1, 0);
      end else begin
        e = exp_bus.pop_front();
        chk("bus_kind_we", int'(reg_we), int'(e.wr));
        chk("bus_addr", int'(reg_addr), int'(e.addr));
        if (e.wr) chk("bus_wdata", int'(reg_wdata), int'(e.data));
      end
      if (reg_we) begin n_we++; we_cyc = cyc; end
      if (reg_re) begin n_re++; re_cyc = cyc; end
    end
    if (tx_wren) begin
      if (exp_tx.size() == 0) chk("unexpected_tx_push", 1, 0);
      else chk("tx_byte", int'(tx_byte), int'(exp_tx.pop_front()));
      n_wren++;
      wren_cyc = cyc;
      last_tx  = tx_byte;
    end
    if (frame_err) begin
      if (exp_ferr == 0) chk("unexpected_frame_err", 1, 0);
      else exp_ferr--;
      n_ferr++;
      ferr_cyc = cyc;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s_we, s_re, s_wren, s_ferr, s_pop;
    checks = 0; errors = 0; cyc = 0; exp_ferr = 0;
    n_pop = 0; n_we = 0; n_re = 0; n_wren = 0; n_ferr = 0;
    pop_cyc = 0; we_cyc = 0; re_cyc = 0; wren_cyc = 0; ferr_cyc = 0; last_tx = '0;
    for (int i = 0; i < 256; i++) begin
      bus_regs[i] = 8'(i * 7 + 3);
      mdl_regs[i] = 8'(i * 7 + 3);
    end
    bus_regs[8'h34] = 8'h5C;
    mdl_regs[8'h34] = 8'h5C;
    rst_n = 1'b0; tx_full = 1'b0; reg_rdata = '0;
    rxq.push_back(8'h57);
    rx_update();

    // Reset state, with a byte waiting that must not be popped.
    #12;
    chk("rst_rx_rden", int'(rx_rden), 0);
    chk("rst_tx_wren", int'(tx_wren), 0);
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_reg_re", int'(reg_re), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_reg_addr", int'(reg_addr), 0);
    chk("rst_reg_wdata", int'(reg_wdata), 0);
    rxq.delete();
    rx_update();
    @(posedge CLK); #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Write frame.
    s_we = n_we; s_wren = n_wren; s_re = n_re;
    feed(3, 8'h57, 8'h12, 8'hA5, 1);
    wait_done("write", 50);
    chk("wr_we_count", n_we - s_we, 1);
    chk("wr_re_count", n_re - s_re, 0);
    chk("wr_push_count", n_wren - s_wren, 1);
    chk("wr_we_latency", we_cyc - pop_cyc, 1);
    chk("wr_push_latency", wren_cyc - pop_cyc, 2);
    chk("wr_reply", int'(last_tx), 8'h06);
    chk("wr_reg_written", int'(bus_regs[8'h12]), 8'hA5);
    chk("wr_busy_idle", int'(busy), 0);
    chk("wr_addr_hold", int'(reg_addr), 8'h12);
    chk("wr_wdata_hold", int'(reg_wdata), 8'hA5);

    // Read frame.
    s_we = n_we; s_re = n_re; s_wren = n_wren;
    feed(2, 8'h52, 8'h34, 8'h00, 1);
    wait_done("read", 50);
    chk("rd_re_count", n_re - s_re, 1);
    chk("rd_we_count", n_we - s_we, 0);
    chk("rd_re_latency", re_cyc - pop_cyc, 1);
    chk("rd_push_after_re", wren_cyc - re_cyc, 2);
    chk("rd_reply", int'(last_tx), 8'h5C);

    // Unknown command, then a normal read.
    s_we = n_we; s_re = n_re; s_ferr = n_ferr; s_wren = n_wren;
    feed(1, 8'h41, 8'h00, 8'h00, 1);
    wait_done("bad_cmd", 50);
    chk("bad_ferr_count", n_ferr - s_ferr, 1);
    chk("bad_push_count", n_wren - s_wren, 1);
    chk("bad_reply", int'(last_tx), 8'h15);
    chk("bad_no_bus", (n_we - s_we) + (n_re - s_re), 0);
    feed(2, 8'h52, 8'h00, 8'h00, 1);
    wait_done("after_bad", 50);
    chk("after_bad_reply", int'(last_tx), 8'h03);

    // Inter-byte gaps of TO-1 idle cycles are tolerated.
    s_we = n_we; s_ferr = n_ferr;
    s_pop = n_pop;
    feed(1, 8'h57, 8'h00, 8'h00, 1);
    wait_cnt("slow_cmd", 0, s_pop + 1, 20);
    repeat (TO - 1) tick();
    feed(1, 8'h21, 8'h00, 8'h00, 1);
    wait_cnt("slow_addr", 0, s_pop + 2, 20);
    repeat (TO - 1) tick();
    feed(1, 8'h9E, 8'h00, 8'h00, 1);
    wait_done("slow", 50);
    chk("slow_ferr_count", n_ferr - s_ferr, 0);
    chk("slow_we_count", n_we - s_we, 1);
    chk("slow_reg_written", int'(bus_regs[8'h21]), 8'h9E);

    // Timeout abort after ADDR.
    s_we = n_we; s_ferr = n_ferr; s_wren = n_wren;
    feed(2, 8'h57, 8'h10, 8'h00, 0);
    exp_ferr++;
    wait_done("timeout", 100);
    chk("to_ferr_count", n_ferr - s_ferr, 1);
    chk("to_ferr_latency", ferr_cyc - pop_cyc, 16);
    chk("to_no_we", n_we - s_we, 0);
    chk("to_no_push", n_wren - s_wren, 0);
    feed(2, 8'h52, 8'h10, 8'h00, 1);
    wait_done("after_timeout", 50);
    chk("after_to_reply", int'(last_tx), 8'h73);

    // Back-pressure on the reply with another frame already queued.
    tx_full = 1'b1;
    s_re = n_re;
    feed(2, 8'h52, 8'h05, 8'h00, 1);
    feed(2, 8'h52, 8'h01, 8'h00, 1);
    wait_cnt("bp_first_re", 1, s_re + 1, 20);
    s_pop = n_pop; s_wren = n_wren;
    repeat (100) tick();
    chk("bp_no_push", n_wren - s_wren, 0);
    chk("bp_no_pop", n_pop - s_pop, 0);
    chk("bp_queued", rxq.size(), 2);
    chk("bp_busy", int'(busy), 1);
    tx_full = 1'b0;
    wait_cnt("bp_push", 2, s_wren + 1, 10);
    chk("bp_first_reply", int'(last_tx), 8'h26);
    wait_cnt("bp_next_pop", 0, s_pop + 1, 10);
    chk("b2b_gap", pop_cyc - wren_cyc, 1);
    wait_done("bp", 50);
    chk("bp_push_count", n_wren - s_wren, 2);
    chk("bp_second_reply", int'(last_tx), 8'h0A);

    // Reset between ADDR and DATA of a write.
    s_pop = n_pop;
    feed(2, 8'h57, 8'h20, 8'h00, 0);
    wait_cnt("mid_pops", 0, s_pop + 2, 20);
    repeat (2) tick();
    chk("mid_busy", int'(busy), 1);
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_reg_addr", int'(reg_addr), 0);
    chk("mid_rst_tx_byte", int'(tx_byte), 0);
    chk("mid_rst_strobes", int'(reg_we) + int'(reg_re) + int'(tx_wren) + int'(rx_rden), 0);
    @(posedge CLK); #1;
    repeat (2) tick();
    rst_n = 1'b1;
    s_we = n_we; s_wren = n_wren;
    repeat (30) tick();
    chk("mid_no_we", n_we - s_we, 0);
    chk("mid_no_push", n_wren - s_wren, 0);
    feed(2, 8'h52, 8'h20, 8'h00, 1);
    wait_done("after_reset", 50);
    chk("after_rst_reply", int'(last_tx), 8'hE3);

    chk("left_bus", exp_bus.size(), 0);
    chk("left_tx", exp_tx.size(), 0);
    chk("left_ferr", exp_ferr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Command responder on the host side of the UART byte interface.
- Pops bytes from the UART RX FIFO and decodes read and write register frames.
- Performs the register access on a simple 8-bit register bus, then pushes the reply byte into the UART TX FIFO.
- Sits between the uart top (RX/TX FIFO ports) and on-chip control registers, giving a PC a way to peek and poke registers over the serial link.

Parameters:
- ADDR_W, 8, register address width; taken from the low ADDR_W bits of the address byte (1..8).
- TIMEOUT, 50000, inter-byte timeout in CLK cycles while a frame is incomplete; 0 disables the timeout.

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_byte  input  8  head of RX FIFO; first-word-fall-through, valid whenever rx_empty=0.
- rx_empty  input  1  RX FIFO empty.
- rx_rden  output  1  RX FIFO pop, one-cycle pulse.
- tx_byte  output  8  reply byte to TX FIFO.
- tx_full  input  1  TX FIFO full.
- tx_wren  output  1  TX FIFO push, one-cycle pulse.
- reg_addr  output  ADDR_W  register address.
- reg_wdata  output  8  register write data.
- reg_we  output  1  write strobe, one cycle.
- reg_re  output  1  read strobe, one cycle.
- reg_rdata  input  8  read data, valid exactly one cycle after reg_re.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse on NAK or timeout abort.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_rden, tx_wren, reg_we, reg_re, busy, frame_err = 0; tx_byte, reg_addr, reg_wdata, timeout counter = 0.
- Frame formats:
  - Write: 0x57, ADDR, DATA. Reply 0x06.
  - Read: 0x52, ADDR. Reply is the read data.
  - Any other first byte: reply 0x15 (NAK) with a frame_err pulse; the byte is consumed.
- Byte consumption:
  - In IDLE, GET_ADDR and GET_DATA, when rx_empty=0, assert rx_rden for exactly one cycle.
  - rx_byte is captured in that same cycle and the state advances on the next edge.
  - No byte is ever popped in any other state.
- State machine:
  - IDLE: on 0x57 go to GET_ADDR with the write flag set. On 0x52 go to GET_ADDR with the write flag clear. On any other byte, load tx_byte=0x15, pulse frame_err, go to SEND.
  - GET_ADDR: capture reg_addr <= rx_byte[ADDR_W-1:0]. Next state is GET_DATA if write, else BUS_RD.
  - GET_DATA: capture reg_wdata <= rx_byte, go to BUS_WR.
  - BUS_WR: reg_we=1 for one cycle, load tx_byte=0x06, go to SEND.
  - BUS_RD: reg_re=1 for one cycle, go to RD_WAIT.
  - RD_WAIT: tx_byte <= reg_rdata, go to SEND.
  - SEND: hold until tx_full=0, then tx_wren=1 for one cycle with tx_byte stable, go to IDLE.
- Outputs: reg_addr and reg_wdata hold their last values outside strobes.
- Latency:
  - Last frame byte popped at edge N; reg_we at N+1; tx_wren at N+2 if TX has room.
  - Read: reg_re at N+1, tx_wren at N+3.
- Timeout:
  - The counter clears on every pop and counts up in GET_ADDR and GET_DATA while rx_empty=1.
  - When the count reaches TIMEOUT-1 (TIMEOUT≠0): pulse frame_err, return to IDLE, no bus access, no reply.
  - The counter is held at 0 in all other states.
- Back-pressure:
  - tx_full may stay high indefinitely; the block waits in SEND and performs no RX pops.
  - Bytes arriving meanwhile stay queued in the RX FIFO.
- Back-to-back frames: a new frame may start in the cycle after the SEND push. There is no idle gap beyond the IDLE pop cycle.
- Strobe exclusivity:
  - reg_we and reg_re are never both high.
  - rx_rden and tx_wren are never both high.
  - rx_rden is never high while rx_empty=1.
  - tx_wren is never high while tx_full=1.
- Reset mid-frame: the frame is abandoned immediately, with no strobe or reply issued after rst_n deasserts.

Test Plan:
- Write: feed 0x57,0x12,0xA5 into the RX FIFO model -> one reg_we with reg_addr=0x12, reg_wdata=0xA5; then one tx_wren with tx_byte=0x06; busy back to 0.
- Read: feed 0x52,0x34 with the register model returning 0x5C -> one reg_re with reg_addr=0x34; tx_byte=0x5C pushed exactly 2 cycles after reg_re.
- Bad command: feed 0x41 -> frame_err pulse, tx_byte=0x15 pushed, no reg_we/reg_re; then 0x52,0x00 is processed normally.
- Timeout: TIMEOUT=16, feed 0x57,0x10 then silence -> frame_err exactly 16 cycles after the last pop, no reg_we, no tx_wren. A following 0x52,0x10 returns the read data.
- Back-pressure: hold tx_full=1 for 100 cycles during a read reply, with 0x52,0x01 already queued -> tx_wren stays low and no rx_rden occurs. After release, exactly one push, then the queued frame is processed.
- Reset: assert rst_n=0 between the ADDR and DATA bytes of a write -> all outputs 0 asynchronously. After release, 0x06 is never sent and no reg_we is issued for the abandoned frame.
